// File: rtl/operand_aligner_if.sv
// Operand aligner bus: two upstream valid/ready operand streams, flush, and the
// aligned downstream pair with occupancy and issue-count status.
interface operand_aligner_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned LvlW = $clog2(DEPTH) + 1;

  logic             in_a_valid;
  logic [WIDTH-1:0] in_a_data;
  logic             in_a_ready;
  logic             in_b_valid;
  logic [WIDTH-1:0] in_b_data;
  logic             in_b_ready;
  logic             flush;
  logic             a_valid;
  logic [WIDTH-1:0] a;
  logic             b_valid;
  logic [WIDTH-1:0] b;
  logic [LvlW-1:0]  a_level;
  logic [LvlW-1:0]  b_level;
  logic [CNT_W-1:0] pair_count;

  modport master (
    output in_a_valid, in_a_data, in_b_valid, in_b_data, flush,
    input  in_a_ready, in_b_ready, a_valid, a, b_valid, b, a_level, b_level, pair_count
  );

  modport slave (
    input  in_a_valid, in_a_data, in_b_valid, in_b_data, flush,
    output in_a_ready, in_b_ready, a_valid, a, b_valid, b, a_level, b_level, pair_count
  );
endinterface

// File: rtl/operand_aligner.sv
// Buffers two operand streams in per-stream FIFOs and issues them strictly as
// aligned pairs, so the downstream a_valid/b_valid are always asserted together.
module operand_aligner #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  operand_aligner_if.slave bus_io
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef logic [WIDTH-1:0] word_t;

  word_t            mem_a_q [DEPTH];
  word_t            mem_b_q [DEPTH];
  logic [PtrW-1:0]  a_wr_q, a_wr_d, a_rd_q, a_rd_d;
  logic [PtrW-1:0]  b_wr_q, b_wr_d, b_rd_q, b_rd_d;
  logic [LvlW-1:0]  a_lvl_q, a_lvl_d, b_lvl_q, b_lvl_d;
  logic             vld_q, vld_d;
  word_t            a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic pop, a_rdy, b_rdy, push_a, push_b;

  // Pop depends only on registered levels and flush, never on the input valids.
  always_comb begin
    pop    = (a_lvl_q != '0) && (b_lvl_q != '0) && !bus_io.flush;
    a_rdy  = !bus_io.flush && ((a_lvl_q != LvlW'(DEPTH)) || pop);
    b_rdy  = !bus_io.flush && ((b_lvl_q != LvlW'(DEPTH)) || pop);
    push_a = bus_io.in_a_valid && a_rdy;
    push_b = bus_io.in_b_valid && b_rdy;
  end

  always_comb begin
    a_wr_d  = a_wr_q;
    a_rd_d  = a_rd_q;
    a_lvl_d = a_lvl_q;
    b_wr_d  = b_wr_q;
    b_rd_d  = b_rd_q;
    b_lvl_d = b_lvl_q;
    if (bus_io.flush) begin
      a_wr_d  = '0;
      a_rd_d  = '0;
      a_lvl_d = '0;
      b_wr_d  = '0;
      b_rd_d  = '0;
      b_lvl_d = '0;
    end else begin
      if (push_a) a_wr_d = a_wr_q + PtrW'(1);
      if (push_b) b_wr_d = b_wr_q + PtrW'(1);
      if (pop) begin
        a_rd_d = a_rd_q + PtrW'(1);
        b_rd_d = b_rd_q + PtrW'(1);
      end
      unique case ({push_a, pop})
        2'b10:   a_lvl_d = a_lvl_q + LvlW'(1);
        2'b01:   a_lvl_d = a_lvl_q - LvlW'(1);
        default: a_lvl_d = a_lvl_q;
      endcase
      unique case ({push_b, pop})
        2'b10:   b_lvl_d = b_lvl_q + LvlW'(1);
        2'b01:   b_lvl_d = b_lvl_q - LvlW'(1);
        default: b_lvl_d = b_lvl_q;
      endcase
    end
  end

  // Outputs return to zero on any non-issuing cycle; the consumer never stalls.
  always_comb begin
    vld_d = pop;
    a_d   = pop ? mem_a_q[a_rd_q] : '0;
    b_d   = pop ? mem_b_q[b_rd_q] : '0;
    cnt_d = pop ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_wr_q  <= '0;
      a_rd_q  <= '0;
      a_lvl_q <= '0;
      b_wr_q  <= '0;
      b_rd_q  <= '0;
      b_lvl_q <= '0;
      vld_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      a_wr_q  <= a_wr_d;
      a_rd_q  <= a_rd_d;
      a_lvl_q <= a_lvl_d;
      b_wr_q  <= b_wr_d;
      b_rd_q  <= b_rd_d;
      b_lvl_q <= b_lvl_d;
      vld_q   <= vld_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read once counted in the level.
  always_ff @(posedge clk) begin
    if (push_a) mem_a_q[a_wr_q] <= bus_io.in_a_data;
    if (push_b) mem_b_q[b_wr_q] <= bus_io.in_b_data;
  end

  assign bus_io.in_a_ready = a_rdy;
  assign bus_io.in_b_ready = b_rdy;
  assign bus_io.a_valid    = vld_q;
  assign bus_io.b_valid    = vld_q;
  assign bus_io.a          = a_q;
  assign bus_io.b          = b_q;
  assign bus_io.a_level    = a_lvl_q;
  assign bus_io.b_level    = b_lvl_q;
  assign bus_io.pair_count = cnt_q;
endmodule
